max_finder: RTL and testbench

- Output-layer classifier stage that sits directly downstream of the last neuron layer.
- Captures the parallel vector of numInput neuron outputs in one handshake.
- Scans the captured vector sequentially and reports the index and value of the largest output, i.e. the recognised digit.
- Feeds the top-level result register and the bench scoreboard.

---
 rtl/nn_pkg.sv | 19 +
 rtl/max_finder_if.sv | 36 +++
 rtl/max_finder.sv | 103 ++++++++++
 tb/tb_max_finder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the classifier output stage: default frame geometry,
// the max-finder FSM state type and the index-width helper.
package nn_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } mf_state_e;

    // A single-element frame still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_finder_if.sv
// Frame-in / result-out bundle between the last neuron layer and the max finder.
// master = upstream producer and result consumer, slave = max_finder.
interface max_finder_if #(
    parameter int numInput  = nn_pkg::NUM_CLASSES,
    parameter int dataWidth = nn_pkg::DATA_WIDTH
) ();
    import nn_pkg::*;

    localparam int IdxWidth = idx_width(numInput);

    logic                          in_valid;
    logic [numInput*dataWidth-1:0] in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic [IdxWidth-1:0]           out_index;
    logic [dataWidth-1:0]          out_max;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_index,
        input  out_max
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_index,
        output out_max
    );

endinterface

// File: rtl/max_finder.sv
// Captures one layer output vector, scans it one element per cycle and reports
// the index and value of the largest signed element (lowest index wins ties).
//
// state   | meaning
// IDLE    | waiting for a frame, in_ready high
// SCAN    | comparing buffered element cnt against running max, in_ready low
// DONE    | result on outputs with out_valid high; may accept the next frame
module max_finder
    import nn_pkg::*;
#(
    parameter int numInput  = nn_pkg::NUM_CLASSES,
    parameter int dataWidth = nn_pkg::DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    max_finder_if.slave   bus
);

    localparam int                  IdxWidth = idx_width(numInput);
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(numInput - 1);
    localparam logic [IdxWidth-1:0] OneIdx   = IdxWidth'(1);

    mf_state_e             state_q, state_d;
    logic [dataWidth-1:0]  max_q, max_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [IdxWidth-1:0]   cnt_q, cnt_d;
    logic                  out_valid_q;
    logic [IdxWidth-1:0]   out_index_q;
    logic [dataWidth-1:0]  out_max_q;
    logic [dataWidth-1:0]  data_buf_q [numInput];
    logic                  accept;

    assign bus.in_ready  = (state_q != ST_SCAN);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_max   = out_max_q;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SCAN: begin
                if ($signed(data_buf_q[cnt_q]) > $signed(max_q)) begin
                    max_d = data_buf_q[cnt_q];
                    idx_d = cnt_q;
                end
                // Counter stops at the last element so it never wraps.
                if (cnt_q == LastIdx) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + OneIdx;
                end
            end
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    max_d   = bus.in_data[dataWidth-1:0];
                    idx_d   = '0;
                    cnt_d   = OneIdx;
                    state_d = (numInput > 1) ? ST_SCAN : ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results are latched on entry to DONE so they hold through later scans.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                out_index_q <= idx_d;
                out_max_q   <= max_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < numInput; i++) begin
                data_buf_q[i] <= bus.in_data[i*dataWidth +: dataWidth];
            end
        end
    end

endmodule

// File: tb/tb_max_finder.sv
// Directed bench for max_finder: a 10-input instance for the main scenarios and
// a 1-input instance for the degenerate frame size.
module tb_max_finder;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    max_finder_if #(.numInput(10), .dataWidth(16)) bus10 ();
    max_finder_if #(.numInput(1),  .dataWidth(16)) bus1 ();

    max_finder #(.numInput(10), .dataWidth(16)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10.slave)
    );

    max_finder #(.numInput(1), .dataWidth(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [159:0] fill(input logic [15:0] val);
        logic [159:0] v;
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = val;
        return v;
    endfunction

    function automatic logic [159:0] basic_vec();
        logic [159:0] v;
        v = fill(16'h0000);
        v[0*16 +: 16] = 16'd5;
        v[1*16 +: 16] = 16'd9;
        v[2*16 +: 16] = 16'd2;
        v[3*16 +: 16] = 16'd3;
        v[4*16 +: 16] = 16'd4;
        v[5*16 +: 16] = 16'd6;
        v[6*16 +: 16] = 16'd8;
        v[7*16 +: 16] = 16'h7FFF;
        v[8*16 +: 16] = 16'd1;
        v[9*16 +: 16] = 16'd0;
        return v;
    endfunction

    // Presents one frame from idle, then waits (bounded) for the result pulse.
    task automatic send_frame(input logic [159:0] v, output int lat, output int busy,
                              output logic [3:0] idx, output logic [15:0] mx);
        @(negedge clk);
        bus10.in_valid = 1'b1;
        bus10.in_data  = v;
        @(posedge clk);
        #1;
        bus10.in_valid = 1'b0;
        lat  = -1;
        busy = 0;
        idx  = 'x;
        mx   = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus10.out_valid === 1'b1) begin
                lat = n;
                idx = bus10.out_index;
                mx  = bus10.out_max;
                break;
            end
            if (bus10.in_ready === 1'b0) busy++;
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus10.in_valid = 1'b1;
        bus10.in_data  = basic_vec();
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (bus10.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL reset_out_valid got %b want 0", bus10.out_valid);
        end
        vec_cnt++;
        if (bus10.out_index !== 4'd0) begin
            err_cnt++; $display("FAIL reset_out_index got %0d want 0", bus10.out_index);
        end
        vec_cnt++;
        if (bus10.out_max !== 16'h0000) begin
            err_cnt++; $display("FAIL reset_out_max got %h want 0000", bus10.out_max);
        end
        vec_cnt++;
        if (bus10.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL reset_in_ready got %b want 1", bus10.in_ready);
        end
        rst            = 1'b0;
        bus10.in_valid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (bus10.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL reset_override_no_capture in_ready got %b want 1", bus10.in_ready);
        end
        vec_cnt++;
        if (bus1.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL reset_n1_out_valid got %b want 0", bus1.out_valid);
        end
    endtask

    task automatic test_basic();
        int          lat, busy;
        logic [3:0]  idx;
        logic [15:0] mx;
        send_frame(basic_vec(), lat, busy, idx, mx);
        vec_cnt++;
        if (lat !== 10) begin
            err_cnt++; $display("FAIL basic_latency got %0d want 10", lat);
        end
        vec_cnt++;
        if (busy !== 9) begin
            err_cnt++; $display("FAIL basic_busy_cycles got %0d want 9", busy);
        end
        vec_cnt++;
        if (idx !== 4'd7) begin
            err_cnt++; $display("FAIL basic_index got %0d want 7", idx);
        end
        vec_cnt++;
        if (mx !== 16'h7FFF) begin
            err_cnt++; $display("FAIL basic_max got %h want 7fff", mx);
        end
        @(negedge clk);
        vec_cnt++;
        if (bus10.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL basic_pulse_width out_valid got %b want 0", bus10.out_valid);
        end
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (bus10.out_index !== 4'd7 || bus10.out_max !== 16'h7FFF) begin
            err_cnt++; $display("FAIL basic_hold got %0d/%h want 7/7fff", bus10.out_index, bus10.out_max);
        end
    endtask

    task automatic test_tie_negative();
        int           lat, busy;
        logic [3:0]   idx;
        logic [15:0]  mx;
        logic [159:0] v;
        v = fill(16'hFF00);
        v[3*16 +: 16] = 16'h0100;
        v[8*16 +: 16] = 16'h0100;
        send_frame(v, lat, busy, idx, mx);
        vec_cnt++;
        if (idx !== 4'd3 || mx !== 16'h0100) begin
            err_cnt++; $display("FAIL tie_lowest_index got %0d/%h want 3/0100", idx, mx);
        end
        v = fill(16'hFFFB);
        v[4*16 +: 16] = 16'hFFFF;
        send_frame(v, lat, busy, idx, mx);
        vec_cnt++;
        if (idx !== 4'd4 || mx !== 16'hFFFF) begin
            err_cnt++; $display("FAIL all_negative got %0d/%h want 4/ffff", idx, mx);
        end
        vec_cnt++;
        if (lat !== 10) begin
            err_cnt++; $display("FAIL all_negative_latency got %0d want 10", lat);
        end
    endtask

    // Two frames with in_valid held: the second is taken in the first's DONE cycle.
    task automatic two_frame_run(input string tag, input logic [159:0] a, input logic [159:0] b,
                                 input logic [159:0] noise,
                                 input logic [3:0] idx_a, input logic [15:0] max_a,
                                 input logic [3:0] idx_b, input logic [15:0] max_b);
        int          pulses, n1, n2;
        logic [3:0]  i1, i2;
        logic [15:0] m1, m2;
        pulses = 0; n1 = -1; n2 = -1; i1 = 'x; i2 = 'x; m1 = 'x; m2 = 'x;
        @(negedge clk);
        bus10.in_valid = 1'b1;
        bus10.in_data  = a;
        @(posedge clk);
        #1;
        bus10.in_data  = b;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (bus10.out_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin n1 = n; i1 = bus10.out_index; m1 = bus10.out_max; end
                if (pulses == 2) begin n2 = n; i2 = bus10.out_index; m2 = bus10.out_max; end
            end
            if (n == 4) bus10.in_data = noise;
            if (n == 6) bus10.in_data = b;
            if (n == 11) begin
                vec_cnt++;
                if (bus10.in_ready !== 1'b0) begin
                    err_cnt++; $display("FAIL %s_second_accepted_in_done in_ready got %b want 0", tag, bus10.in_ready);
                end
                bus10.in_valid = 1'b0;
            end
        end
        vec_cnt++;
        if (pulses !== 2) begin
            err_cnt++; $display("FAIL %s_pulse_count got %0d want 2", tag, pulses);
        end
        vec_cnt++;
        if (n1 !== 10 || i1 !== idx_a || m1 !== max_a) begin
            err_cnt++; $display("FAIL %s_first got t%0d %0d/%h want t10 %0d/%h", tag, n1, i1, m1, idx_a, max_a);
        end
        vec_cnt++;
        if (n2 !== 20 || i2 !== idx_b || m2 !== max_b) begin
            err_cnt++; $display("FAIL %s_second got t%0d %0d/%h want t20 %0d/%h", tag, n2, i2, m2, idx_b, max_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [159:0] a, b;
        a = fill(16'h0010);
        a[9*16 +: 16] = 16'h0020;
        b = fill(16'h0040);
        b[0*16 +: 16] = 16'h0050;
        two_frame_run("b2b", a, b, b, 4'd9, 16'h0020, 4'd0, 16'h0050);
    endtask

    task automatic test_busy_ignore();
        logic [159:0] a, b, x;
        a = fill(16'h0001);
        a[2*16 +: 16] = 16'h0100;
        b = fill(16'h0001);
        b[6*16 +: 16] = 16'h0200;
        x = fill(16'h0000);
        x[5*16 +: 16] = 16'h7FFF;
        two_frame_run("busy", a, b, x, 4'd2, 16'h0100, 4'd6, 16'h0200);
    endtask

    task automatic test_reset_mid();
        int           pulses, lat, busy;
        logic [3:0]   idx;
        logic [15:0]  mx;
        logic [159:0] v;
        pulses = 0;
        @(negedge clk);
        bus10.in_valid = 1'b1;
        bus10.in_data  = basic_vec();
        @(posedge clk);
        #1;
        bus10.in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus10.out_valid === 1'b1) pulses++;
            if (n == 3) rst = 1'b1;
            if (n == 4) begin
                vec_cnt++;
                if (bus10.out_index !== 4'd0 || bus10.out_max !== 16'h0000) begin
                    err_cnt++; $display("FAIL rstmid_outputs got %0d/%h want 0/0000", bus10.out_index, bus10.out_max);
                end
                rst = 1'b0;
            end
            if (n == 5) begin
                vec_cnt++;
                if (bus10.in_ready !== 1'b1) begin
                    err_cnt++; $display("FAIL rstmid_in_ready got %b want 1", bus10.in_ready);
                end
            end
        end
        vec_cnt++;
        if (pulses !== 0) begin
            err_cnt++; $display("FAIL rstmid_no_out_valid got %0d pulses want 0", pulses);
        end
        v = fill(16'h8000);
        v[5*16 +: 16] = 16'h0003;
        send_frame(v, lat, busy, idx, mx);
        vec_cnt++;
        if (lat !== 10 || idx !== 4'd5 || mx !== 16'h0003) begin
            err_cnt++; $display("FAIL rstmid_next_frame got t%0d %0d/%h want t10 5/0003", lat, idx, mx);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        vec_cnt++;
        if (bus1.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL n1_idle_ready got %b want 1", bus1.in_ready);
        end
        bus1.in_valid = 1'b1;
        bus1.in_data  = 16'h1234;
        @(posedge clk);
        #1;
        bus1.in_data  = 16'hFFF0;
        @(negedge clk);
        vec_cnt++;
        if (bus1.out_valid !== 1'b1 || bus1.out_index !== 1'b0 || bus1.out_max !== 16'h1234) begin
            err_cnt++; $display("FAIL n1_first got v%b %0d/%h want v1 0/1234", bus1.out_valid, bus1.out_index, bus1.out_max);
        end
        vec_cnt++;
        if (bus1.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL n1_ready_in_done got %b want 1", bus1.in_ready);
        end
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (bus1.out_valid !== 1'b1 || bus1.out_max !== 16'hFFF0) begin
            err_cnt++; $display("FAIL n1_second got v%b %h want v1 fff0", bus1.out_valid, bus1.out_max);
        end
        @(negedge clk);
        vec_cnt++;
        if (bus1.out_valid !== 1'b0 || bus1.out_max !== 16'hFFF0 || bus1.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL n1_idle_after got v%b %h r%b want v0 fff0 r1", bus1.out_valid, bus1.out_max, bus1.in_ready);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_basic();
        test_tie_negative();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_single();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
